// File: rtl/aurras_audio_pkg.sv
// Shared constants and types for the Aurras audio front end.
package aurras_audio_pkg;

    localparam int AUDIO_CLK_HZ  = 98_304_000;
    localparam int FRAME_RATE_HZ = 48_000;
    localparam int NUM_MICS      = 3;
    localparam int SAMPLE_W      = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Mic clock generator: stopped (counters parked at 0) or running.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } clk_state_t;

endpackage

// File: rtl/i2s_slot_deserializer.sv
// One mic data line: 2-flop synchroniser feeding an MSB-first shift register.
// sample_next_o is the value the register takes this cycle, so the top can
// commit a word on the same edge that shifts in its last bit.
module i2s_slot_deserializer #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                data_i,
    input  logic                clear_i,
    input  logic                shift_i,
    output logic [SAMPLE_W-1:0] sample_next_o
);

    logic [1:0]          sync_q;
    logic [SAMPLE_W-1:0] shift_q;
    logic [SAMPLE_W-1:0] shift_d;

    // Bring the asynchronous mic line into the clk_i domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[0], data_i};
    end

    // Shift the synchronised bit in on the strobe; drop partial data when stopped.
    always_comb begin
        shift_d = shift_q;
        if (clear_i)      shift_d = '0;
        else if (shift_i) shift_d = (shift_q << 1) | SAMPLE_W'(sync_q[1]);
    end

    // Shift register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) shift_q <= '0;
        else       shift_q <= shift_d;
    end

    assign sample_next_o = shift_d;

endmodule

// File: rtl/i2s_mic_array.sv
// N-channel I2S MEMS-mic receiver: shared BCLK/LRCL generation, lockstep
// capture of every data line, and one frame-aligned output with valid/ready.
// Handshake: a frame transfers on any cycle with data_valid_out && data_ready_in;
// audio_out only changes while valid is high when a new frame is committed.
module i2s_mic_array #(
    parameter int NUM_CH    = aurras_audio_pkg::NUM_MICS,
    parameter int BCLK_DIV  = 32,
    parameter int SLOT_BITS = 32,
    parameter int SAMPLE_W  = aurras_audio_pkg::SAMPLE_W
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       enable_in,
    input  logic [NUM_CH-1:0]          mic_data_in,
    output logic                       i2s_clk_out,
    output logic                       lrcl_clk_out,
    output logic [NUM_CH*SAMPLE_W-1:0] audio_out,
    output logic                       data_valid_out,
    input  logic                       data_ready_in,
    output logic                       overrun_out,
    input  logic                       clear_overrun_in,
    output logic [15:0]                frame_count_out
);

    import aurras_audio_pkg::*;

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] WIN_LAST   = BIT_W'(SAMPLE_W);

    clk_state_t                 state_q, state_d;
    logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic                       i2s_clk_q, lrcl_q;
    logic [NUM_CH*SAMPLE_W-1:0] audio_q, audio_d;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;
    logic [NUM_CH*SAMPLE_W-1:0] capture;
    logic                       strobe, shift_en, commit;

    // Counter FSM: counters are parked at 0 when stopped, so leaving IDLE is the first tick.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (enable_in) begin
                    state_d   = ST_RUN;
                    div_cnt_d = DIV_ONE;
                end
            end
            ST_RUN: begin
                if (!enable_in) begin
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_ONE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sample at the end of the BCLK high phase; slot bit 0 is the I2S delay bit.
    assign strobe   = (state_q == ST_RUN) && enable_in && (div_cnt_q == DIV_LAST);
    assign shift_en = strobe && (bit_cnt_q != '0) && (bit_cnt_q <= WIN_LAST);
    assign commit   = strobe && (bit_cnt_q == WIN_LAST);

    // Counter state and registered mic clocks (both follow the next counter values).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            i2s_clk_q <= 1'b0;
            lrcl_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            i2s_clk_q <= (div_cnt_d >= DIV_HALF);
            lrcl_q    <= (bit_cnt_d >= SLOT_START);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        i2s_slot_deserializer #(
            .SAMPLE_W (SAMPLE_W)
        ) u_deser (
            .clk_i         (clk_in),
            .rst_i         (rst_in),
            .data_i        (mic_data_in[k]),
            .clear_i       (!enable_in),
            .shift_i       (shift_en),
            .sample_next_o (capture[k*SAMPLE_W +: SAMPLE_W])
        );
    end

    // Output frame, handshake and sticky overrun; a new overrun beats a clear.
    always_comb begin
        audio_d     = audio_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        if (valid_q && data_ready_in) valid_d = 1'b0;
        if (clear_overrun_in)         overrun_d = 1'b0;
        if (commit) begin
            audio_d     = capture;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (valid_q && !data_ready_in) overrun_d = 1'b1;
        end
    end

    // Output register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            audio_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            audio_q     <= audio_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign i2s_clk_out     = i2s_clk_q;
    assign lrcl_clk_out    = lrcl_q;
    assign audio_out       = audio_q;
    assign data_valid_out  = valid_q;
    assign overrun_out     = overrun_q;
    assign frame_count_out = frame_cnt_q;

endmodule

// File: tb/tb_i2s_mic_array.sv
// Directed bench for i2s_mic_array: 3-channel default build plus a 1-channel
// 24-bit build fed from mic 0. Expected frame timing comes from a small model
// of enable history (commit at 544 cycles after enable, then every 2048).
module tb_i2s_mic_array;

    logic        clk = 1'b0;
    logic        rst, enable, ready, clear_ovr;
    logic [2:0]  mic;
    logic        i2s_clk, lrcl, valid, overrun;
    logic [47:0] audio;
    logic [15:0] fcount;
    logic        i2s_clk2, lrcl2, valid2, overrun2;
    logic [23:0] audio2;
    logic [15:0] fcount2;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int en_at = 0;
    int fc_base = 0;
    logic [23:0] mic_word [3];
    int   pos = 0;
    logic prev_b = 1'b0;
    logic prev_l = 1'b0;

    i2s_mic_array dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .enable_in        (enable),
        .mic_data_in      (mic),
        .i2s_clk_out      (i2s_clk),
        .lrcl_clk_out     (lrcl),
        .audio_out        (audio),
        .data_valid_out   (valid),
        .data_ready_in    (ready),
        .overrun_out      (overrun),
        .clear_overrun_in (clear_ovr),
        .frame_count_out  (fcount)
    );

    i2s_mic_array #(.NUM_CH(1), .SAMPLE_W(24)) dut24 (
        .clk_in           (clk),
        .rst_in           (rst),
        .enable_in        (enable),
        .mic_data_in      (mic[0]),
        .i2s_clk_out      (i2s_clk2),
        .lrcl_clk_out     (lrcl2),
        .audio_out        (audio2),
        .data_valid_out   (valid2),
        .data_ready_in    (1'b1),
        .overrun_out      (overrun2),
        .clear_overrun_in (1'b0),
        .frame_count_out  (fcount2)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mic models: 24-bit words MSB-first after the delay bit in the left slot, random junk elsewhere.
    always @(negedge clk) begin
        if (!enable || rst)            pos = 0;
        else if (lrcl !== prev_l)      pos = 0;
        else if (prev_b && !i2s_clk)   pos = pos + 1;
        prev_b = i2s_clk;
        prev_l = lrcl;
        for (int k = 0; k < 3; k++) begin
            if (!lrcl && pos >= 1 && pos <= 24) mic[k] = mic_word[k][24-pos];
            else                                 mic[k] = 1'($urandom_range(0, 1));
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic int frames_since(input int start, input int now);
        if (now < start + 544) return 0;
        return (now - start - 544) / 2048 + 1;
    endfunction

    function automatic int exp_fc();
        return enable ? fc_base + frames_since(en_at, cyc) : fc_base;
    endfunction

    function automatic int next_commit();
        return en_at + 544 + 2048 * frames_since(en_at, cyc);
    endfunction

    function automatic logic cur(input int sel);
        return (sel == 0) ? i2s_clk : lrcl;
    endfunction

    // Number of negedges the selected clock holds its present level (bounded).
    task automatic run_length(input int sel, output int n);
        logic lvl;
        lvl = cur(sel);
        n = 0;
        while (cur(sel) == lvl && n < 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n_a, n_b, c1, c2, d, guard;
        rst = 1'b1; enable = 1'b0; ready = 1'b1; clear_ovr = 1'b0;
        mic_word[0] = 24'h8001A5; mic_word[1] = 24'h7FFEA5; mic_word[2] = 24'h1234A5;
        repeat (2) @(negedge clk);

        check_eq("rst_i2s_clk", i2s_clk, 0);
        check_eq("rst_lrcl", lrcl, 0);
        check_eq("rst_audio", audio, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_frame_count", fcount, 0);

        // Free-running capture with ready held high.
        rst = 1'b0; enable = 1'b1; en_at = cyc;
        wait_until(en_at + 543);
        check_eq("t1_valid_before_commit", valid, 0);
        wait_until(en_at + 544);
        check_eq("t1_first_commit_valid", valid, 1);
        check_eq("t2_audio_frame", audio, 48'h1234_7FFE_8001);
        check_eq("t1_frame_count", fcount, 64'(exp_fc()));
        check_eq("t1_overrun_idle", overrun, 0);
        check_eq("t1_lrcl_low_first", lrcl, 0);
        wait_until(en_at + 545);
        check_eq("t1_valid_one_cycle", valid, 0);
        wait_until(en_at + 850);
        check_eq("t6_variant_audio24", audio2, 24'h8001A5);
        check_eq("t6_variant_frames", fcount2, 1);
        run_length(0, n_a);
        run_length(0, n_a);
        run_length(0, n_b);
        check_eq("t1_bclk_phase_a", n_a, 16);
        check_eq("t1_bclk_phase_b", n_b, 16);
        wait_until(en_at + 1023);
        check_eq("t1_lrcl_low_end", lrcl, 0);
        wait_until(en_at + 1024);
        check_eq("t1_lrcl_rise", lrcl, 1);
        run_length(1, n_a);
        run_length(1, n_b);
        check_eq("t1_lrcl_high_len", n_a, 1024);
        check_eq("t1_lrcl_low_len", n_b, 1024);

        // Overrun: two commits while ready is low.
        ready = 1'b0;
        c1 = next_commit();
        wait_until(c1);
        check_eq("t3_frame_a_valid", valid, 1);
        check_eq("t3_frame_a", audio, 48'h1234_7FFE_8001);
        check_eq("t3_no_overrun_yet", overrun, 0);
        mic_word[0] = 24'hFFFF00; mic_word[1] = 24'h000100; mic_word[2] = 24'hC0DE5A;
        wait_until(c1 + 2047);
        check_eq("t3_hold_a", audio, 48'h1234_7FFE_8001);
        check_eq("t3_hold_valid", valid, 1);
        wait_until(c1 + 2048);
        check_eq("t3_frame_b", audio, 48'hC0DE_0001_FFFF);
        check_eq("t3_valid_kept", valid, 1);
        check_eq("t3_overrun_set", overrun, 1);
        check_eq("t3_frame_count", fcount, 64'(exp_fc()));
        clear_ovr = 1'b1;
        wait_until(c1 + 2049);
        clear_ovr = 1'b0;
        check_eq("t3_overrun_cleared", overrun, 0);
        check_eq("t3_valid_after_clear", valid, 1);

        // Ready pulsed exactly on the commit cycle.
        mic_word[0] = 24'h55AA00; mic_word[1] = 24'hAA5500; mic_word[2] = 24'h0F0F00;
        c2 = c1 + 4096;
        wait_until(c2 - 1);
        check_eq("t4_hold_b", audio, 48'hC0DE_0001_FFFF);
        ready = 1'b1;
        wait_until(c2);
        ready = 1'b0;
        check_eq("t4_frame_c", audio, 48'h0F0F_AA55_55AA);
        check_eq("t4_valid_kept", valid, 1);
        check_eq("t4_no_overrun", overrun, 0);
        check_eq("t4_frame_count", fcount, 64'(exp_fc()));

        // Disable at slot bit 10 (BCLK high), then re-enable.
        d = c2 + 1845;
        wait_until(d);
        check_eq("t5_bclk_high_before", i2s_clk, 1);
        enable = 1'b0;
        fc_base = fc_base + frames_since(en_at, d);
        wait_until(d + 1);
        check_eq("t5_bclk_low", i2s_clk, 0);
        check_eq("t5_lrcl_low", lrcl, 0);
        check_eq("t5_frame_held", valid, 1);
        check_eq("t5_audio_held", audio, 48'h0F0F_AA55_55AA);
        wait_until(d + 50);
        check_eq("t5_count_frozen", fcount, 64'(exp_fc()));
        check_eq("t5_bclk_stays_low", i2s_clk, 0);
        mic_word[0] = 24'h7FFF00; mic_word[1] = 24'h800000; mic_word[2] = 24'h00013C;
        ready = 1'b1;
        wait_until(d + 51);
        check_eq("t5_held_frame_taken", valid, 0);
        wait_until(d + 60);
        enable = 1'b1; en_at = cyc;
        wait_until(en_at + 543);
        check_eq("t5_no_early_commit", valid, 0);
        wait_until(en_at + 544);
        check_eq("t5_commit_544", valid, 1);
        check_eq("t5_frame_d", audio, 48'h0001_8000_7FFF);
        check_eq("t5_frame_count", fcount, 64'(exp_fc()));
        ready = 1'b0;

        // Asynchronous reset mid-frame, away from any clock edge.
        guard = 0;
        while (!(i2s_clk && lrcl) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("t6_found_right_slot", guard < 3000, 1);
        check_eq("t6_pre_valid", valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_i2s_clk", i2s_clk, 0);
        check_eq("t6_rst_lrcl", lrcl, 0);
        check_eq("t6_rst_audio", audio, 0);
        check_eq("t6_rst_valid", valid, 0);
        check_eq("t6_rst_overrun", overrun, 0);
        check_eq("t6_rst_frame_count", fcount, 0);
        check_eq("t6_rst_variant_audio", audio2, 0);
        check_eq("t6_rst_variant_count", fcount2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
